// File: rtl/fen_encode_pkg.sv
// rtl/fen_encode_pkg.sv - square codes, castle bits, ASCII constants and emit FSM state for the FEN encoder
package fen_encode_pkg;

   localparam logic [2:0] SQ_EMPTY   = 3'd0;
   localparam logic [2:0] SQ_PAWN    = 3'd1;
   localparam logic [2:0] SQ_KNIGHT  = 3'd2;
   localparam logic [2:0] SQ_BISHOP  = 3'd3;
   localparam logic [2:0] SQ_ROOK    = 3'd4;
   localparam logic [2:0] SQ_QUEEN   = 3'd5;
   localparam logic [2:0] SQ_KING    = 3'd6;
   localparam logic [2:0] SQ_ILLEGAL = 3'd7;
   localparam int         SQ_WHITE_BIT = 3;

   localparam int CASTLE_WK = 0;
   localparam int CASTLE_WQ = 1;
   localparam int CASTLE_BK = 2;
   localparam int CASTLE_BQ = 3;

   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_SLASH = 8'h2f;
   localparam logic [7:0] ASCII_DASH  = 8'h2d;
   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_QMARK = 8'h3f;

   typedef enum logic [3:0] {
      ST_IDLE, ST_PIECES, ST_SP1, ST_TURN, ST_SP2, ST_CASTLE,
      ST_SP3, ST_EP, ST_SP4, ST_HM, ST_SP5, ST_FM
   } emit_state_e;

   // Decimal digits needed for the largest w-bit value (log10(2) ~= 0.30103).
   function automatic int dec_digits(input int w);
      return (w * 30103) / 100000 + 1;
   endfunction

   function automatic logic [7:0] piece_ascii(input logic [3:0] code);
      logic [7:0] c;
      case (code[2:0])
         SQ_PAWN:   c = 8'h50;
         SQ_KNIGHT: c = 8'h4e;
         SQ_BISHOP: c = 8'h42;
         SQ_ROOK:   c = 8'h52;
         SQ_QUEEN:  c = 8'h51;
         SQ_KING:   c = 8'h4b;
         default:   c = ASCII_QMARK;
      endcase
      if (code[2:0] != SQ_ILLEGAL && code[2:0] != SQ_EMPTY && !code[SQ_WHITE_BIT])
         c = c | 8'h20;
      return c;
   endfunction

endpackage

// File: rtl/fen_encode_if.sv
// rtl/fen_encode_if.sv - square-beat input stream and ASCII output stream of the FEN encoder
interface fen_encode_if #(
   parameter int CNT_W = 16,
   parameter int SQ_W  = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [SQ_W-1:0]  in_data;
   logic             in_sop;
   logic             in_eop;
   logic             in_wtp;
   logic [3:0]       in_castle;
   logic             in_ep_valid;
   logic [2:0]       in_ep_file;
   logic [CNT_W-1:0] in_hmcount;
   logic [CNT_W-1:0] in_fmcount;
   logic             out_valid;
   logic             out_ready;
   logic [7:0]       out_data;
   logic             out_sop;
   logic             out_eop;

   modport master (
      output in_valid, in_data, in_sop, in_eop, in_wtp, in_castle,
             in_ep_valid, in_ep_file, in_hmcount, in_fmcount, out_ready,
      input  in_ready, out_valid, out_data, out_sop, out_eop
   );

   modport slave (
      input  in_valid, in_data, in_sop, in_eop, in_wtp, in_castle,
             in_ep_valid, in_ep_file, in_hmcount, in_fmcount, out_ready,
      output in_ready, out_valid, out_data, out_sop, out_eop
   );
endinterface

// File: rtl/fen_encode_bin_to_ascii.sv
// rtl/fen_encode_bin_to_ascii.sv - sequential double-dabble binary to BCD with significant digit count
module bin_to_ascii_int
   import fen_encode_pkg::*;
#(
   parameter int CNT_W = 16,
   parameter int ND    = dec_digits(CNT_W),
   parameter int NW    = $clog2(ND + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [CNT_W-1:0] bin_i,
   output logic             done_o,
   output logic [4*ND-1:0]  bcd_o,
   output logic [NW-1:0]    ndig_o
);
   localparam int CW = $clog2(CNT_W + 1);

   logic [CNT_W-1:0] sh_q;
   logic [4*ND-1:0]  bcd_q;
   logic [4*ND-1:0]  adj;
   logic [CW-1:0]    cnt_q;
   logic             busy_q;
   logic             done_q;

   always_comb begin
      adj = bcd_q;
      for (int d = 0; d < ND; d++)
         if (bcd_q[4*d +: 4] >= 4'd5) adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
   end

   // done stays high until the next start so the consumer can pick the result up late.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_q   <= '0;
         bcd_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else if (start_i) begin
         sh_q   <= bin_i;
         bcd_q  <= '0;
         cnt_q  <= CW'(CNT_W);
         busy_q <= 1'b1;
         done_q <= 1'b0;
      end else if (busy_q) begin
         bcd_q <= {adj[4*ND-2:0], sh_q[CNT_W-1]};
         sh_q  <= sh_q << 1;
         cnt_q <= cnt_q - 1'b1;
         if (cnt_q == CW'(1)) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
         end
      end
   end

   always_comb begin
      ndig_o = NW'(1);
      for (int d = 0; d < ND; d++)
         if (bcd_q[4*d +: 4] != 4'd0) ndig_o = NW'(d + 1);
   end

   assign done_o = done_q;
   assign bcd_o  = bcd_q;

endmodule

// File: rtl/fen_encode.sv
// rtl/fen_encode.sv - buffers a 64-square position plus side-state and streams it out as a FEN record
module fen_encode
   import fen_encode_pkg::*;
#(
   parameter int CNT_W = 16,
   parameter int SQ_W  = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   fen_encode_if.slave bus,
   output logic        o_err
);
   localparam int ND = dec_digits(CNT_W);
   localparam int NW = $clog2(ND + 1);

   emit_state_e          state_q, state_d;
   logic [5:0]           cnt_q, cnt_d;
   logic [SQ_W-1:0]      sq_mem [64];
   logic [7:0][SQ_W-1:0] row_q;
   logic [2:0]           rk_q, rk_d;
   logic [3:0]           file_q, file_d;
   logic                 pc_q, pc_d;
   logic [3:0]           castle_q, castle_d;
   logic [NW-1:0]        dig_q, dig_d;
   logic                 wtp_q, ep_valid_q;
   logic [2:0]           ep_file_q;
   logic [CNT_W-1:0]     fm_q;
   logic [4*ND-1:0]      hm_bcd_q;
   logic [NW-1:0]        hm_n_q;
   logic                 hm_rdy_q;
   logic                 ov_q, osop_q, oeop_q;
   logic [7:0]           od_q;
   logic                 err_q;

   logic             in_fire, eop_ok, bad;
   logic [5:0]       wr_idx;
   logic             conv_start, conv_done, hm_capture;
   logic [CNT_W-1:0] conv_bin;
   logic [4*ND-1:0]  conv_bcd;
   logic [NW-1:0]    conv_ndig;
   logic             adv, emit, e_sop, e_eop;
   logic [7:0]       e_data;
   logic [3:0]       run, cur4, low_bit;
   logic             stop;
   logic [NW-1:0]    hm_idx, fm_idx;

   assign bus.in_ready  = (state_q == ST_IDLE) && !ov_q;
   assign bus.out_valid = ov_q;
   assign bus.out_data  = od_q;
   assign bus.out_sop   = osop_q;
   assign bus.out_eop   = oeop_q;
   assign o_err         = err_q;

   // in_sop always restarts the packet at square 0, even mid-packet.
   assign in_fire = bus.in_valid && bus.in_ready;
   assign wr_idx  = bus.in_sop ? 6'd0 : cnt_q;
   assign eop_ok  = in_fire && bus.in_eop && (wr_idx == 6'd63);
   assign bad     = in_fire && (bus.in_eop ? (wr_idx != 6'd63) : (wr_idx == 6'd63));
   assign cnt_d   = in_fire ? ((bus.in_eop || wr_idx == 6'd63) ? 6'd0 : wr_idx + 6'd1) : cnt_q;

   always_ff @(posedge clk) begin
      if (in_fire) sq_mem[wr_idx] <= bus.in_data;
   end

   // One converter: halfmove first, its digits parked, then fullmove.
   assign hm_capture = (state_q != ST_IDLE) && !hm_rdy_q && conv_done;
   assign conv_start = eop_ok || hm_capture;
   assign conv_bin   = eop_ok ? bus.in_hmcount : fm_q;

   bin_to_ascii_int #(.CNT_W(CNT_W), .ND(ND), .NW(NW)) u_conv (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (conv_start),
      .bin_i   (conv_bin),
      .done_o  (conv_done),
      .bcd_o   (conv_bcd),
      .ndig_o  (conv_ndig)
   );

   assign adv     = !ov_q || bus.out_ready;
   assign cur4    = 4'(row_q[file_q[2:0]]);
   assign low_bit = castle_q & (~castle_q + 4'd1);
   assign hm_idx  = hm_n_q - dig_q - 1'b1;
   assign fm_idx  = conv_ndig - dig_q - 1'b1;

   always_comb begin
      state_d  = state_q;
      rk_d     = rk_q;
      file_d   = file_q;
      pc_d     = pc_q;
      castle_d = castle_q;
      dig_d    = dig_q;
      emit     = 1'b0;
      e_data   = 8'd0;
      e_sop    = 1'b0;
      e_eop    = 1'b0;
      run      = 4'd0;
      stop     = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (i >= int'(file_q) && !stop) begin
            if (row_q[i][2:0] == SQ_EMPTY) run = run + 4'd1;
            else stop = 1'b1;
         end
      end
      case (state_q)
         ST_IDLE: begin
            if (eop_ok) begin
               state_d  = ST_PIECES;
               rk_d     = 3'd0;
               file_d   = 4'd0;
               pc_d     = 1'b0;
               castle_d = bus.in_castle;
            end
         end
         ST_PIECES: begin
            emit  = 1'b1;
            e_sop = (rk_q == 3'd0) && (file_q == 4'd0) && !pc_q;
            // file_q == 8 means the rank is finished and only its '/' remains.
            if (file_q[3]) begin
               e_data = ASCII_SLASH;
               if (adv) begin
                  rk_d   = rk_q + 3'd1;
                  file_d = 4'd0;
               end
            end else if (pc_q || run == 4'd0) begin
               e_data = piece_ascii(cur4);
               if (adv) begin
                  pc_d   = 1'b0;
                  file_d = file_q + 4'd1;
                  if (file_q == 4'd7 && rk_q == 3'd7) state_d = ST_SP1;
               end
            end else begin
               e_data = ASCII_ZERO + {4'd0, run};
               if (adv) begin
                  file_d = file_q + run;
                  pc_d   = (file_q + run) != 4'd8;
                  if ((file_q + run) == 4'd8 && rk_q == 3'd7) state_d = ST_SP1;
               end
            end
         end
         ST_SP1, ST_SP2, ST_SP3, ST_SP4, ST_SP5: begin
            emit   = 1'b1;
            e_data = ASCII_SPACE;
            dig_d  = '0;
            if (adv) state_d = emit_state_e'(state_q + 4'd1);
         end
         ST_TURN: begin
            emit   = 1'b1;
            e_data = wtp_q ? 8'h77 : 8'h62;
            if (adv) state_d = ST_SP2;
         end
         ST_CASTLE: begin
            emit = 1'b1;
            if (castle_q == 4'd0) begin
               e_data = ASCII_DASH;
               if (adv) state_d = ST_SP3;
            end else begin
               if (low_bit[CASTLE_WK])      e_data = 8'h4b;
               else if (low_bit[CASTLE_WQ]) e_data = 8'h51;
               else if (low_bit[CASTLE_BK]) e_data = 8'h6b;
               else                         e_data = 8'h71;
               if (adv) begin
                  castle_d = castle_q & ~low_bit;
                  if ((castle_q & ~low_bit) == 4'd0) state_d = ST_SP3;
               end
            end
         end
         ST_EP: begin
            emit = 1'b1;
            if (!ep_valid_q) begin
               e_data = ASCII_DASH;
               if (adv) state_d = ST_SP4;
            end else if (!pc_q) begin
               e_data = 8'h61 + {5'd0, ep_file_q};
               if (adv) pc_d = 1'b1;
            end else begin
               e_data = wtp_q ? 8'h36 : 8'h33;
               if (adv) begin
                  pc_d    = 1'b0;
                  state_d = ST_SP4;
               end
            end
         end
         ST_HM: begin
            if (hm_rdy_q) begin
               emit   = 1'b1;
               e_data = ASCII_ZERO + {4'd0, hm_bcd_q[{hm_idx, 2'b00} +: 4]};
               if (adv) begin
                  dig_d = dig_q + 1'b1;
                  if (hm_idx == '0) state_d = ST_SP5;
               end
            end
         end
         ST_FM: begin
            if (hm_rdy_q && conv_done) begin
               emit   = 1'b1;
               e_data = ASCII_ZERO + {4'd0, conv_bcd[{fm_idx, 2'b00} +: 4]};
               e_eop  = (fm_idx == '0);
               if (adv) begin
                  dig_d = dig_q + 1'b1;
                  if (fm_idx == '0) state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 6'd0;
         row_q      <= '0;
         rk_q       <= 3'd0;
         file_q     <= 4'd0;
         pc_q       <= 1'b0;
         castle_q   <= 4'd0;
         dig_q      <= '0;
         wtp_q      <= 1'b0;
         ep_valid_q <= 1'b0;
         ep_file_q  <= 3'd0;
         fm_q       <= '0;
         hm_bcd_q   <= '0;
         hm_n_q     <= '0;
         hm_rdy_q   <= 1'b0;
         ov_q       <= 1'b0;
         od_q       <= 8'd0;
         osop_q     <= 1'b0;
         oeop_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rk_q     <= rk_d;
         file_q   <= file_d;
         pc_q     <= pc_d;
         castle_q <= castle_d;
         dig_q    <= dig_d;
         err_q    <= bad;
         for (int i = 0; i < 8; i++) row_q[i] <= sq_mem[{rk_d, 3'(i)}];
         if (eop_ok) begin
            wtp_q      <= bus.in_wtp;
            ep_valid_q <= bus.in_ep_valid;
            ep_file_q  <= bus.in_ep_file;
            fm_q       <= bus.in_fmcount;
            hm_rdy_q   <= 1'b0;
         end else if (hm_capture) begin
            hm_bcd_q <= conv_bcd;
            hm_n_q   <= conv_ndig;
            hm_rdy_q <= 1'b1;
         end
         if (emit && adv) begin
            ov_q   <= 1'b1;
            od_q   <= e_data;
            osop_q <= e_sop;
            oeop_q <= e_eop;
         end else if (bus.out_ready) begin
            ov_q <= 1'b0;
         end
      end
   end

endmodule
